fetch_unit: RTL

Instruction fetch stage of the simple CPU. It sits directly upstream of the decode stage, which splits each 16-bit word into opcode[15:12], src1[11:8], src2[7:4] and dest[3:0]. It owns the PC and issues reads to a synchronous instruction memory with 1-cycle latency. Fetched words go through a 2-entry buffer and are presented to decode under a valid/ready handshake, with support for redirect (branch/jump) and halt.

---
 rtl/simple_cpu_pkg.sv | 41 ++++
 rtl/fetch_unit_if.sv | 33 +++
 rtl/fetch_buffer.sv | 82 ++++++++
 rtl/fetch_unit.sv | 97 +++++++++
 4 files changed

// File: rtl/simple_cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : simple_cpu_pkg
//  Purpose  : Instruction format and opcode constants shared by fetch and decode
//  Revision : 1.0
// ============================================================================
package simple_cpu_pkg;

  localparam int INSTR_W    = 16;
  localparam int OPCODE_W   = 4;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int SRC1_MSB   = 11;
  localparam int SRC1_LSB   = 8;
  localparam int SRC2_MSB   = 7;
  localparam int SRC2_LSB   = 4;
  localparam int DEST_MSB   = 3;
  localparam int DEST_LSB   = 0;

  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP   = 4'h0,
    OP_ADD   = 4'h1,
    OP_SUB   = 4'h2,
    OP_AND   = 4'h3,
    OP_OR    = 4'h4,
    OP_XOR   = 4'h5,
    OP_LOAD  = 4'h6,
    OP_STORE = 4'h7,
    OP_BEQ   = 4'h8,
    OP_JMP   = 4'h9,
    OP_HALT  = 4'hF
  } opcode_e;

  function automatic logic [OPCODE_W-1:0] get_opcode(input instr_t word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Interface : fetch_unit_if
//  Purpose   : Instruction-memory read port plus fetch-to-decode handshake
//  Revision  : 1.0
// ============================================================================
interface fetch_unit_if #(
  parameter int ADDR_W = 8
);

  logic                        o_imem_en;
  logic [ADDR_W-1:0]           o_imem_addr;
  simple_cpu_pkg::instr_t      i_imem_rdata;
  simple_cpu_pkg::instr_t      o_instruction;
  logic [ADDR_W-1:0]           o_pc;
  logic                        o_valid;
  logic                        i_ready;
  logic                        i_redirect;
  logic [ADDR_W-1:0]           i_redirect_pc;
  logic                        o_halted;

  modport master (
    output o_imem_en, o_imem_addr, o_instruction, o_pc, o_valid, o_halted,
    input  i_imem_rdata, i_ready, i_redirect, i_redirect_pc
  );

  modport slave (
    input  o_imem_en, o_imem_addr, o_instruction, o_pc, o_valid, o_halted,
    output i_imem_rdata, i_ready, i_redirect, i_redirect_pc
  );

endinterface
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_buffer
//  Purpose  : 2-entry FIFO of {pc, instruction} with flush and head output
//  Revision : 1.0
// ============================================================================
module fetch_buffer
  import simple_cpu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_pc,
  input  instr_t            i_instr,
  input  logic              i_pop,
  input  logic              i_flush,
  output logic [1:0]        o_count,
  output logic [ADDR_W-1:0] o_head_pc,
  output instr_t            o_head_instr
);

  logic [ADDR_W-1:0] pc_q    [2];
  logic [ADDR_W-1:0] pc_d    [2];
  instr_t            instr_q [2];
  instr_t            instr_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;

  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    // Flush keeps the storage; only pointers and occupancy are cleared.
    if (i_flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (i_push) begin
        pc_d[wr_ptr_q]    = i_pc;
        instr_d[wr_ptr_q] = i_instr;
        wr_ptr_d          = ~wr_ptr_q;
      end
      if (i_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q[0]    <= '0;
      pc_q[1]    <= '0;
      instr_q[0] <= '0;
      instr_q[1] <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign o_count      = count_q;
  assign o_head_pc    = pc_q[rd_ptr_q];
  assign o_head_instr = instr_q[rd_ptr_q];

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_push && !i_pop && !i_flush && (count_q == 2'd2)));

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : PC owner and instruction fetch with 2-deep buffer, redirect, halt
//  Revision : 1.0
// ============================================================================
module fetch_unit
  import simple_cpu_pkg::*;
#(
  parameter int                    ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0,
  parameter logic [OPCODE_W-1:0]   HALT_OP  = OP_HALT
) (
  input  logic         i_clk,
  input  logic         i_rst,
  fetch_unit_if.master bus
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              halted_q, halted_d;

  logic [1:0]        count;
  logic [ADDR_W-1:0] head_pc;
  instr_t            head_instr;
  logic              valid;
  logic              pop;
  logic              push;
  logic              issue;
  logic [2:0]        occupancy;
  logic [ADDR_W-1:0] issue_addr;

  assign valid      = (count != 2'd0) & ~bus.i_redirect;
  assign pop        = valid & bus.i_ready;
  assign occupancy  = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
  // A redirect discards everything outstanding, so it never waits for credit.
  assign issue      = ~i_rst & ~halted_q & (bus.i_redirect | (occupancy < 3'd2));
  assign issue_addr = bus.i_redirect ? bus.i_redirect_pc : pc_q;
  assign push       = inflight_q & ~bus.i_redirect & ~halted_q;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    halted_d      = halted_q;
    if (issue) begin
      pc_d          = issue_addr + ADDR_W'(1);
      inflight_pc_d = issue_addr;
    end else if (bus.i_redirect) begin
      pc_d = bus.i_redirect_pc;
    end
    if (bus.i_redirect) begin
      halted_d = 1'b0;
    end else if (push && (get_opcode(bus.i_imem_rdata) == HALT_OP)) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      halted_q      <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      halted_q      <= halted_d;
    end
  end

  fetch_buffer #(
    .ADDR_W (ADDR_W)
  ) u_fetch_buffer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_push       (push),
    .i_pc         (inflight_pc_q),
    .i_instr      (bus.i_imem_rdata),
    .i_pop        (pop),
    .i_flush      (bus.i_redirect),
    .o_count      (count),
    .o_head_pc    (head_pc),
    .o_head_instr (head_instr)
  );

  assign bus.o_imem_en     = issue;
  assign bus.o_imem_addr   = issue_addr;
  assign bus.o_valid       = valid;
  assign bus.o_pc          = head_pc;
  assign bus.o_instruction = head_instr;
  assign bus.o_halted      = halted_q;

endmodule
`default_nettype wire
